// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter onto a slow strobed byte RAM; `define SRAM_ARB_RR_EN for round-robin ties.
module sram_arbiter #(
  parameter int ACCESS_CYCLES  = 32,
  parameter int GAP_CYCLES     = 3,
  parameter int STARTUP_CYCLES = 10240
) (
  input  logic        clk_sdram,
  input  logic        init,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [24:0] p0_addr,
  input  logic [7:0]  p0_din,
  output logic        p0_ack,
  output logic [7:0]  p0_dout,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [24:0] p1_addr,
  input  logic [7:0]  p1_din,
  output logic        p1_ack,
  output logic [7:0]  p1_dout,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        ready
);
  typedef enum logic [2:0] {STARTUP, IDLE, ACCESS, ACK, GAP} state_t;
  localparam int MX = (STARTUP_CYCLES > ACCESS_CYCLES) ?
                      ((STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES) :
                      ((ACCESS_CYCLES > GAP_CYCLES) ? ACCESS_CYCLES : GAP_CYCLES);
  localparam int CW = $clog2(MX + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, lim;
  logic cnt_last, gnt, we, pick1, grant;
  always_comb begin
    lim = (state == STARTUP) ? CW'(STARTUP_CYCLES - 1) :
          (state == ACCESS)  ? CW'(ACCESS_CYCLES - 1) : CW'(GAP_CYCLES - 1);
    cnt_last = cnt == lim;
    grant = (state == IDLE) && (p0_req || p1_req);
`ifdef SRAM_ARB_RR_EN
    // gnt doubles as the last-grant record: a tie goes to the port not served last
    pick1 = p1_req && (!p0_req || !gnt);
`else
    pick1 = p1_req && !p0_req;
`endif
    mem_rd = (state == ACCESS) && !we;
    mem_we = (state == ACCESS) && we;
    p0_ack = (state == ACK) && !gnt;
    p1_ack = (state == ACK) && gnt;
  end
  always_comb begin
    state_nx = STARTUP;
    case (state)
      STARTUP: state_nx = cnt_last ? IDLE : STARTUP;
      IDLE:    state_nx = grant ? ACCESS : IDLE;
      ACCESS:  state_nx = cnt_last ? ACK : ACCESS;
      ACK:     state_nx = GAP;
      GAP:     state_nx = cnt_last ? IDLE : GAP;
      default: state_nx = STARTUP;
    endcase
  end
  always_ff @(posedge clk_sdram) begin
    if (init) begin
      state    <= STARTUP;
      cnt      <= '0;
      ready    <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      we       <= 1'b0;
      gnt      <= 1'b1;
      p0_dout  <= '0;
      p1_dout  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (state_nx == IDLE) ready <= 1'b1;
      if (grant) begin
        gnt      <= pick1;
        we       <= pick1 ? p1_we : p0_we;
        mem_addr <= pick1 ? p1_addr : p0_addr;
        mem_din  <= pick1 ? p1_din : p0_din;
      end
      // read data is taken on the last strobe cycle so it is valid alongside ack
      if (state == ACCESS && cnt_last && !we && !gnt) p0_dout <= mem_dout;
      if (state == ACCESS && cnt_last && !we && gnt) p1_dout <= mem_dout;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with default parameters.
module tb_sram_arbiter;
  logic clk, init;
  logic p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
  logic [24:0] p0_addr, p1_addr, mem_addr;
  logic [7:0] p0_din, p0_dout, p1_din, p1_dout, mem_din, mem_dout;
  logic mem_rd, mem_we, ready;
  typedef struct {logic port; logic [7:0] dout;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  sram_arbiter dut (
    .clk_sdram(clk), .init(init),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_ack(p1_ack), .p1_dout(p1_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_rd(mem_rd), .mem_we(mem_we), .ready(ready)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;
  // byte RAM model: read data derived from the address
  always_comb mem_dout = mem_addr[7:0] ^ 8'h91;

  task automatic startup_wait(output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
      if (mem_rd || mem_we || p0_ack || p1_ack) seen = 1'b1;
    end
  endtask

  task automatic wait_ack(output int lat, output int rd_n, output int we_n, output int pre,
                          output logic port, output logic bad, output logic [24:0] a, output logic [7:0] d);
    lat = 0; rd_n = 0; we_n = 0; pre = 0; port = 1'b0; bad = 1'b0; a = '0; d = '0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_rd && mem_we) bad = 1'b1;
      if ((mem_rd || mem_we) && rd_n + we_n == 0) begin
        a = mem_addr;
        d = mem_din;
      end else if ((mem_rd || mem_we) && (mem_addr !== a || mem_din !== d)) bad = 1'b1;
      if (!(mem_rd || mem_we) && rd_n + we_n == 0) pre++;
      rd_n += int'(mem_rd);
      we_n += int'(mem_we);
      if (p0_ack || p1_ack) begin
        port = p1_ack;
        if (p0_ack && p1_ack) bad = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    logic seen;
    init = 1'b1; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 25'h0001234; p0_din = 8'h00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_din = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({ready, mem_rd, mem_we, p0_ack, p1_ack} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {ready, mem_rd, mem_we, p0_ack, p1_ack}); end
    checks++; if (mem_addr !== 25'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    checks++; if (mem_din !== 8'h0) begin errors++; $display("FAIL reset_din got %h exp 0", mem_din); end
    checks++; if ({p0_dout, p1_dout} !== 16'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", {p0_dout, p1_dout}); end
    init = 1'b0;
    startup_wait(n, seen);
    checks++; if (n !== 10240) begin errors++; $display("FAIL startup_len got %0d exp 10240", n); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL startup_quiet got %b exp 0", seen); end
  endtask

  task automatic test_read;
    int lat, rd_n, we_n, pre;
    logic port, bad;
    logic [24:0] a;
    logic [7:0] d;
    exp_t e;
    sb.push_back('{1'b0, 8'hA5});
    wait_ack(lat, rd_n, we_n, pre, port, bad, a, d);
    p0_req = 1'b0;
    e = sb.pop_front();
    checks++; if (lat !== 33) begin errors++; $display("FAIL read_lat got %0d exp 33", lat); end
    checks++; if (rd_n !== 32 || we_n !== 0) begin errors++; $display("FAIL read_strobes got rd=%0d we=%0d exp rd=32 we=0", rd_n, we_n); end
    checks++; if (pre !== 0) begin errors++; $display("FAIL read_first_grant got %0d exp 0", pre); end
    checks++; if (port !== e.port) begin errors++; $display("FAIL read_port got %b exp %b", port, e.port); end
    checks++; if (p0_dout !== e.dout) begin errors++; $display("FAIL read_dout got %h exp %h", p0_dout, e.dout); end
    checks++; if (a !== 25'h0001234 || bad !== 1'b0) begin errors++; $display("FAIL read_addr got %h bad=%b exp 0001234 bad=0", a, bad); end
    @(negedge clk);
    checks++; if ({p0_ack, p1_ack, mem_rd, mem_we} !== 4'b0) begin errors++; $display("FAIL read_ack_pulse got %b exp 0000", {p0_ack, p1_ack, mem_rd, mem_we}); end
    checks++; if (ready !== 1'b1 || p0_dout !== 8'hA5) begin errors++; $display("FAIL read_hold got ready=%b dout=%h exp ready=1 dout=a5", ready, p0_dout); end
  endtask

  task automatic test_write;
    int lat, rd_n, we_n, pre;
    logic port, bad;
    logic [24:0] a;
    logic [7:0] d;
    exp_t e;
    repeat (6) @(negedge clk);
    p1_we = 1'b1; p1_addr = 25'h1FFFFFF; p1_din = 8'h3C; p1_req = 1'b1;
    sb.push_back('{1'b1, 8'h00});
    wait_ack(lat, rd_n, we_n, pre, port, bad, a, d);
    p1_req = 1'b0;
    e = sb.pop_front();
    checks++; if (lat !== 33) begin errors++; $display("FAIL write_lat got %0d exp 33", lat); end
    checks++; if (we_n !== 32 || rd_n !== 0) begin errors++; $display("FAIL write_strobes got we=%0d rd=%0d exp we=32 rd=0", we_n, rd_n); end
    checks++; if (a !== 25'h1FFFFFF || d !== 8'h3C || bad !== 1'b0) begin errors++; $display("FAIL write_bus got a=%h d=%h bad=%b exp 1ffffff 3c 0", a, d, bad); end
    checks++; if (port !== e.port) begin errors++; $display("FAIL write_port got %b exp %b", port, e.port); end
    checks++; if (p1_dout !== e.dout || p0_dout !== 8'hA5) begin errors++; $display("FAIL write_dout got p1=%h p0=%h exp p1=%h p0=a5", p1_dout, p0_dout, e.dout); end
    p1_we = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat, rd_n, we_n, pre;
    logic port, bad;
    logic [24:0] a;
    logic [7:0] d;
    exp_t e;
    repeat (6) @(negedge clk);
    p0_addr = 25'h10; p0_req = 1'b1;
    sb.push_back('{1'b0, 8'h81});
    sb.push_back('{1'b0, 8'h80});
    wait_ack(lat, rd_n, we_n, pre, port, bad, a, d);
    p0_addr = 25'h11;
    e = sb.pop_front();
    checks++; if (port !== e.port || p0_dout !== e.dout) begin errors++; $display("FAIL b2b_first got port=%b dout=%h exp port=%b dout=%h", port, p0_dout, e.port, e.dout); end
    wait_ack(lat, rd_n, we_n, pre, port, bad, a, d);
    p0_req = 1'b0;
    e = sb.pop_front();
    checks++; if (port !== e.port || p0_dout !== e.dout) begin errors++; $display("FAIL b2b_second got port=%b dout=%h exp port=%b dout=%h", port, p0_dout, e.port, e.dout); end
    checks++; if (pre !== 4 || lat !== 37) begin errors++; $display("FAIL b2b_gap got low=%0d lat=%0d exp low=4 lat=37", pre, lat); end
    checks++; if (a !== 25'h11 || rd_n !== 32) begin errors++; $display("FAIL b2b_access got a=%h rd=%0d exp a=11 rd=32", a, rd_n); end
  endtask

  task automatic test_init_abort;
    int k, r, n;
    logic seen;
    repeat (6) @(negedge clk);
    p0_addr = 25'h40; p0_req = 1'b1;
    k = 0; r = 0;
    while (r < 10 && k < 100) begin
      @(negedge clk);
      k++;
      r += int'(mem_rd);
    end
    checks++; if (r !== 10 || k !== 10) begin errors++; $display("FAIL abort_reach got rd=%0d cyc=%0d exp 10 10", r, k); end
    init = 1'b1;
    @(negedge clk);
    checks++; if ({mem_rd, mem_we, p0_ack, p1_ack, ready} !== 5'b0) begin errors++; $display("FAIL abort_state got %b exp 00000", {mem_rd, mem_we, p0_ack, p1_ack, ready}); end
    init = 1'b0;
    p0_addr = 25'h20; p1_addr = 25'h31; p1_we = 1'b0; p1_req = 1'b1;
    startup_wait(n, seen);
    checks++; if (n !== 10240 || seen !== 1'b0) begin errors++; $display("FAIL abort_restart got n=%0d seen=%b exp 10240 0", n, seen); end
  endtask

  task automatic test_priority;
    int lat, rd_n, we_n, pre;
    logic port, bad;
    logic [24:0] a;
    logic [7:0] d;
    logic [3:0] order;
    exp_t e;
`ifdef SRAM_ARB_RR_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) sb.push_back('{order[i], order[i] ? 8'hA0 : 8'hB1});
    for (int i = 0; i < 4; i++) begin
      wait_ack(lat, rd_n, we_n, pre, port, bad, a, d);
      e = sb.pop_front();
      checks++; if (port !== e.port) begin errors++; $display("FAIL prio_port%0d got %b exp %b", i, port, e.port); end
      checks++; if ((port ? p1_dout : p0_dout) !== e.dout || bad !== 1'b0) begin errors++; $display("FAIL prio_dout%0d got %h bad=%b exp %h", i, port ? p1_dout : p0_dout, bad, e.dout); end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_init_abort;
    test_priority;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 32, cycles mem_rd/mem_we held high per access (min 16).
REQ-002 SHALL have parameter GAP_CYCLES, default 3, cycles both strobes held low between accesses (min 2).
REQ-003 SHALL have parameter STARTUP_CYCLES, default 10240, cycles after reset before the first grant.
REQ-004 SHALL have ports: clk_sdram in 1 (112 MHz clock, the only clock); init in 1 (synchronous active-high reset).
REQ-005 SHALL have ports: p0_req in 1; p0_we in 1; p0_addr in 25; p0_din in 8; p0_ack out 1; p0_dout out 8 (CPU port).
REQ-006 SHALL have ports: p1_req in 1; p1_we in 1; p1_addr in 25; p1_din in 8; p1_ack out 1; p1_dout out 8 (DMA/loader port).
REQ-007 SHALL have ports: mem_addr out 25; mem_din out 8; mem_dout in 8; mem_rd out 1; mem_we out 1 (to the SDRAM-backed byte RAM).
REQ-008 SHALL have port ready out 1, high once the startup hold-off has expired.

Function
REQ-009 SHALL implement states STARTUP, IDLE, ACCESS, ACK, GAP; any other encoding SHALL go to STARTUP.
REQ-010 STARTUP: count STARTUP_CYCLES, then enter IDLE and set ready=1; ready SHALL stay 1 until init.
REQ-011 IDLE: if any pX_req=1, grant one port, latch its addr/we/din into mem_addr/mem_we-select/mem_din, go to ACCESS next cycle; else stay.
REQ-012 Simultaneous requests: port 0 wins (unless REQ-022 applies).
REQ-013 ACCESS: drive mem_rd=~we or mem_we=we for exactly ACCESS_CYCLES cycles; never both high; mem_addr/mem_din stable throughout.
REQ-014 ACK (1 cycle): both strobes low; capture mem_dout into granted pX_dout on read; pulse granted pX_ack for exactly one cycle; mem_addr held.
REQ-015 Write: pX_ack pulses identically; pX_dout SHALL remain unchanged.
REQ-016 GAP: both strobes low for GAP_CYCLES cycles, then IDLE; guarantees a fresh rising edge for the downstream edge detector.
REQ-017 Timing: req sampled in IDLE at cycle 0 -> strobe high cycles 1..ACCESS_CYCLES -> ack at ACCESS_CYCLES+1 -> next IDLE at ACCESS_CYCLES+GAP_CYCLES+2.
REQ-018 Requester SHALL hold req, we, addr, din stable until ack; the arbiter ignores changes after grant; pX_dout holds until the next read ack on that port.
REQ-019 A port whose req is still high in the IDLE after its ack SHALL be treated as a new request.
REQ-020 Counters SHALL be sized from parameters; no wrap-around within a state.

Reset
REQ-021 init=1 on any clock edge: state=STARTUP, startup counter cleared, ready=0, mem_rd=mem_we=0, mem_addr=0, mem_din=0, p0_ack=p1_ack=0, p0_dout=p1_dout=0, last-grant=port 1; an access in flight is abandoned without ack.

Configuration
REQ-022 Macro SRAM_ARB_RR_EN defined: on simultaneous requests, the port not granted last wins (round-robin); last-grant resets to port 1, so port 0 wins the first tie.
REQ-023 Macro SRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; no last-grant register is implemented.

Verification
REQ-024 Reset, p0_req=1 held -> ready rises and grant occurs only after 10240 cycles; no strobe before that.
REQ-025 Read p0_addr=0x0001234, mem_dout=0xA5 -> mem_rd high 32 cycles, p0_ack one cycle at cycle 33, p0_dout=0xA5, mem_rd low cycles 33..36, IDLE at 37.
REQ-026 Write p1_addr=0x1FFFFFF din=0x3C -> mem_we high 32 cycles, mem_din=0x3C, p1_ack pulse, p1_dout unchanged, mem_rd never high.
REQ-027 Both req held, 4 accesses -> without macro: 0,0,0,0; with SRAM_ARB_RR_EN: 0,1,0,1.
REQ-028 init=1 at cycle 10 of ACCESS -> strobes low next cycle, no ack, ready=0, STARTUP restarted.
REQ-029 p0 back-to-back reads 0x10, 0x11 -> strobe low for at least 4 cycles between accesses (ACK + 3 GAP).
